// File: rtl/frame_streamer.sv
// frame_streamer: reads a stored frame from a synchronous pixel memory, streams
// it one pixel per cycle with en/hsync/vsync framing, and writes the
// pipeline's per-pixel result back to the address the pixel came from.
// Optional feature macro: STREAM_BLANKING_EN inserts HBLANK idle cycles
// between rows. Without it, rows stream back to back.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; all strobes low
// S_ACTIVE | one memory read per cycle, col/row/addr advance every cycle
// S_HBLANK | inter-row gap, no reads (STREAM_BLANKING_EN builds only)
// S_DRAIN  | reads finished, waiting for in-flight results to write back
// S_DONE   | one-cycle done pulse, busy low
module frame_streamer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int PIXEL_SIZE = 24,
    parameter int ADDR_W     = 19,
    parameter int LATENCY    = 4,
    parameter int HBLANK     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [PIXEL_SIZE-1:0] rd_data,
    output logic                  en,
    output logic                  hsync,
    output logic                  vsync,
    output logic [PIXEL_SIZE-1:0] data,
    input  logic [PIXEL_SIZE-1:0] label,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [PIXEL_SIZE-1:0] wr_data
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    // Reject parameter sets the address map or capture pipeline cannot support.
    generate
        if (WIDTH < 1 || HEIGHT < 1 || LATENCY < 1 || LATENCY > 32 || HBLANK < 1 ||
            (64'd1 << ADDR_W) < (64'(WIDTH) * 64'(HEIGHT))) begin : g_bad_params
            $error("frame_streamer: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
`ifdef STREAM_BLANKING_EN
        S_HBLANK,
`endif
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;

    logic              r_en;
    logic              r_hsync;
    logic              r_vsync;
    logic [ADDR_W-1:0] r_pix_addr;

    // Capture pipeline: valid + address of each pixel, LATENCY cycles deep,
    // so the result arriving on label can be matched to its address.
    logic [LATENCY-1:0] r_sv;
    logic [ADDR_W-1:0]  r_sa [LATENCY];

    logic                  r_wr_en;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [PIXEL_SIZE-1:0] r_wr_data;

    logic w_rd_en;
    logic w_row_end;
    logic w_last_pix;
    logic w_pipe_empty;

`ifdef STREAM_BLANKING_EN
    // Down-counter loaded with HBLANK-1 on entry to the gap; leaves at zero.
    localparam int HB_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    logic [HB_W-1:0] r_hb_cnt;

    // Inter-row gap timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hb_cnt <= '0;
        end else if (r_state == S_ACTIVE && w_row_end && !w_last_pix) begin
            r_hb_cnt <= HB_W'(HBLANK - 1);
        end else if (r_state == S_HBLANK && r_hb_cnt != '0) begin
            r_hb_cnt <= r_hb_cnt - 1'b1;
        end
    end
`else
    // No inter-row gap: the column wrap in the counters starts the next row
    // on the very next cycle.
`endif

    assign w_rd_en    = (r_state == S_ACTIVE);
    assign w_row_end  = (r_col == COL_LAST);
    assign w_last_pix = w_row_end && (r_row == ROW_LAST);
    // The write-back register is deliberately left out: done must land in
    // the cycle right after the last wr_en, so DONE is entered while that
    // final write is still on the outputs.
    assign w_pipe_empty = !r_en && (r_sv == '0);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_last_pix) begin
                    w_state_nxt = S_DRAIN;
                end
`ifdef STREAM_BLANKING_EN
                else if (w_row_end) begin
                    w_state_nxt = S_HBLANK;
                end
`endif
            end
`ifdef STREAM_BLANKING_EN
            S_HBLANK: begin
                if (r_hb_cnt == '0) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
`endif
            S_DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pixel position and memory address; cleared when a frame is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (w_rd_en) begin
            r_addr <= r_addr + 1'b1;
            if (w_row_end) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Framing, aligned with the memory's one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en       <= 1'b0;
            r_hsync    <= 1'b0;
            r_vsync    <= 1'b0;
            r_pix_addr <= '0;
        end else begin
            r_en       <= w_rd_en;
            r_hsync    <= w_rd_en && (r_col == '0);
            r_vsync    <= w_rd_en && (r_col == '0) && (r_row == '0);
            r_pix_addr <= r_addr;
        end
    end

    // Carry valid + address alongside the pixel through top's latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sv <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_sa[i] <= '0;
            end
        end else begin
            r_sv[0] <= r_en;
            r_sa[0] <= r_pix_addr;
            for (int i = 1; i < LATENCY; i++) begin
                r_sv[i] <= r_sv[i-1];
                r_sa[i] <= r_sa[i-1];
            end
        end
    end

    // Sample label as each entry leaves the pipeline and register the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= r_sv[LATENCY-1];
            r_wr_addr <= r_sv[LATENCY-1] ? r_sa[LATENCY-1] : '0;
            r_wr_data <= r_sv[LATENCY-1] ? label : '0;
        end
    end

    assign busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done    = (r_state == S_DONE);
    assign rd_en   = w_rd_en;
    assign rd_addr = r_addr;
    assign en      = r_en;
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
    assign data    = r_en ? rd_data : '0;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
